// File: rtl/mem_lsu.sv
// mem_lsu: load/store sequencer between the CPU memory stage and a byte-wide
// single-port data RAM.
//
// Each request becomes one RAM byte access per cycle, least significant byte
// first. Load bytes are assembled, then sign- or zero-extended. Every request
// gets exactly one response.
//
// Ports
//   clock, reset             system clock; synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we                   1 = store, 0 = load
//   req_funct3               RISC-V size/sign code
//   req_addr, req_wdata      byte address and store data (low bytes used)
//   resp_valid/resp_ready    response handshake
//   resp_rdata, resp_err     extended load data and error flag
//   ram_write_ena, ram_addr  RAM write enable and byte address
//   ram_data_o, ram_data_i   RAM write data and combinational read data
//
// Build option
//   MEM_LSU_MISALIGN_EN      when defined, misaligned halfword and word
//                            accesses are legal. Their bytes are sequenced
//                            upward from the address and wrap at the top of
//                            the RAM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for a request
// S_ACCESS | one RAM byte per cycle, idx_q selects the byte
// S_RESP   | response held until resp_ready
module mem_lsu #(
  parameter int DEPTH = 4096,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            ram_write_ena,
  output logic [AW-1:0]   ram_addr,
  output logic [7:0]      ram_data_o,
  input  logic [7:0]      ram_data_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]      state_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      idx_q;
  logic [1:0]      last_q;
  logic            err_q;

  logic            code_ok;
  logic            align_ok;
  logic            legal;
  logic [1:0]      last_d;
  logic            in_access;

  // The RAM is smaller than the address space, so the upper address bits
  // are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[XLEN-1:AW];

  always_comb begin
    code_ok = 1'b0;
    if (req_we) begin
      code_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                (req_funct3 == 3'b010);
    end else begin
      code_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                (req_funct3 == 3'b101);
    end
  end

`ifdef MEM_LSU_MISALIGN_EN
  assign align_ok = 1'b1;
`else
  always_comb begin
    align_ok = 1'b1;
    case (req_funct3[1:0])
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end
`endif

  assign legal = code_ok & align_ok;

  // The index of the last byte: 0, 1 or 3 for byte, halfword or word.
  always_comb begin
    last_d = 2'd0;
    case (req_funct3[1:0])
      2'b00:   last_d = 2'd0;
      2'b01:   last_d = 2'd1;
      default: last_d = 2'd3;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      idx_q    <= 2'd0;
      last_q   <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[AW-1:0];
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            idx_q    <= 2'd0;
            last_q   <= last_d;
            err_q    <= ~legal;
            state_q  <= legal ? S_ACCESS : S_RESP;
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            rdata_q[{idx_q, 3'b000} +: 8] <= ram_data_i;
          end
          idx_q <= idx_q + 2'd1;
          if (idx_q == last_q) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_access  = (state_q == S_ACCESS);
  assign req_ready  = (state_q == S_IDLE) & ~reset;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid & err_q;

  // Reset gates the write enable directly. A store that is cut off by reset
  // keeps the bytes it has already written and writes nothing more.
  assign ram_write_ena = in_access & we_q & ~reset;
  assign ram_addr      = in_access ? (addr_q + AW'(idx_q)) : addr_q;
  assign ram_data_o    = (in_access && we_q) ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;

  always_comb begin
    resp_rdata = '0;
    if (resp_valid && !err_q && !we_q) begin
      case (funct3_q)
        3'b000:  resp_rdata = {{(XLEN-8){rdata_q[7]}}, rdata_q[7:0]};
        3'b001:  resp_rdata = {{(XLEN-16){rdata_q[15]}}, rdata_q[15:0]};
        3'b100:  resp_rdata = {{(XLEN-8){1'b0}}, rdata_q[7:0]};
        3'b101:  resp_rdata = {{(XLEN-16){1'b0}}, rdata_q[15:0]};
        default: resp_rdata = rdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural byte RAM. Latency is counted
// in cycles after the accept edge: cycle 1 is the cycle that follows that edge.
module tb_mem_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_write_ena;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data_o;
  logic [7:0]  ram_data_i;

  logic [7:0]  mem [0:4095];
  logic        poke_we = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          wr;

  always #5 clock = ~clock;

  mem_lsu #(.DEPTH(4096), .XLEN(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .ram_write_ena (ram_write_ena),
    .ram_addr      (ram_addr),
    .ram_data_o    (ram_data_o),
    .ram_data_i    (ram_data_i)
  );

  always @(posedge clock) begin
    if (ram_write_ena) mem[ram_addr] <= ram_data_o;
    else if (poke_we)  mem[poke_addr] <= poke_data;
  end
  assign ram_data_i = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clock);
    poke_we = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clock);
    #1 poke_we = 1'b0;
  endtask

  task automatic send_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    check("req_ready before accept", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int l, output int w);
    l = 0; w = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (resp_valid) begin
        l = c;
        break;
      end
      if (ram_write_ena) w++;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] r, output logic e,
                        output int l, output int w);
    send_req(we, f3, a, wd);
    wait_resp(l, w);
    r = resp_rdata;
    e = resp_err;
    ack();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    poke(12'h010, 8'h80); poke(12'h011, 8'h00); poke(12'h012, 8'h34);
    poke(12'h013, 8'h12); poke(12'h014, 8'h77); poke(12'h030, 8'h01);
    poke(12'h031, 8'hF0); poke(12'h020, 8'h00); poke(12'h021, 8'h00);
    poke(12'h022, 8'h55); poke(12'h023, 8'h00); poke(12'h040, 8'h00);
    poke(12'h041, 8'h00); poke(12'h042, 8'h00); poke(12'h043, 8'h00);

    @(negedge clock);
    check("req_ready in reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset ram_write_ena", 32'(ram_write_ena), 32'd0);
    check("req_ready after reset", 32'(req_ready), 32'd1);

    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, wr);
    check("lw rdata", rd, 32'h12340080);
    check("lw err", 32'(er), 32'd0);
    check("lw latency", 32'(lat), 32'd5);

    do_req(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat, wr);
    check("lb rdata", rd, 32'hFFFFFF80);
    check("lb latency", 32'(lat), 32'd2);
    do_req(1'b0, 3'b100, 32'h10, 32'h0, rd, er, lat, wr);
    check("lbu rdata", rd, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat, wr);
    check("lh rdata", rd, 32'h00001234);
    check("lh latency", 32'(lat), 32'd3);
    do_req(1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat, wr);
    check("lhu rdata", rd, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h30, 32'h0, rd, er, lat, wr);
    check("lh neg rdata", rd, 32'hFFFFF001);

    do_req(1'b1, 3'b001, 32'h20, 32'hDEADBEEF, rd, er, lat, wr);
    check("sh rdata", rd, 32'h0);
    check("sh err", 32'(er), 32'd0);
    check("sh write cycles", 32'(wr), 32'd2);
    check("sh latency", 32'(lat), 32'd3);
    check("sh mem20", 32'(mem[12'h020]), 32'hEF);
    check("sh mem21", 32'(mem[12'h021]), 32'hBE);
    check("sh mem22", 32'(mem[12'h022]), 32'h55);

    do_req(1'b1, 3'b000, 32'h23, 32'h000000A5, rd, er, lat, wr);
    check("sb write cycles", 32'(wr), 32'd1);
    check("sb latency", 32'(lat), 32'd2);
    check("sb mem23", 32'(mem[12'h023]), 32'hA5);

    do_req(1'b1, 3'b011, 32'h50, 32'h12345678, rd, er, lat, wr);
    check("st f3=011 err", 32'(er), 32'd1);
    check("st f3=011 latency", 32'(lat), 32'd1);
    check("st f3=011 writes", 32'(wr), 32'd0);
    check("st f3=011 rdata", rd, 32'h0);
    do_req(1'b0, 3'b110, 32'h10, 32'h0, rd, er, lat, wr);
    check("ld f3=110 err", 32'(er), 32'd1);
    check("ld f3=110 rdata", rd, 32'h0);

    do_req(1'b1, 3'b010, 32'h0000_1FFC, 32'h88776655, rd, er, lat, wr);
    check("sw hi write cycles", 32'(wr), 32'd4);
    check("sw hi memFFC", 32'(mem[12'hFFC]), 32'h55);
    check("sw hi memFFF", 32'(mem[12'hFFF]), 32'h88);
    do_req(1'b0, 3'b010, 32'h0000_1FFC, 32'h0, rd, er, lat, wr);
    check("lw hi rdata", rd, 32'h88776655);

`ifdef MEM_LSU_MISALIGN_EN
    do_req(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat, wr);
    check("lw 0x11 rdata", rd, 32'h77123400);
    check("lw 0x11 err", 32'(er), 32'd0);
    check("lw 0x11 latency", 32'(lat), 32'd5);
    do_req(1'b1, 3'b010, 32'hFFE, 32'h44332211, rd, er, lat, wr);
    check("sw wrap err", 32'(er), 32'd0);
    check("sw wrap memFFE", 32'(mem[12'hFFE]), 32'h11);
    check("sw wrap memFFF", 32'(mem[12'hFFF]), 32'h22);
    check("sw wrap mem000", 32'(mem[12'h000]), 32'h33);
    check("sw wrap mem001", 32'(mem[12'h001]), 32'h44);
`else
    do_req(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat, wr);
    check("lw 0x11 err", 32'(er), 32'd1);
    check("lw 0x11 rdata", rd, 32'h0);
    check("lw 0x11 latency", 32'(lat), 32'd1);
    do_req(1'b1, 3'b001, 32'h21, 32'h0000CAFE, rd, er, lat, wr);
    check("sh 0x21 err", 32'(er), 32'd1);
    check("sh 0x21 writes", 32'(wr), 32'd0);
    check("sh 0x21 mem21", 32'(mem[12'h021]), 32'hBE);
`endif

    // Reset lands in the second ACCESS cycle of a word store.
    send_req(1'b1, 3'b010, 32'h40, 32'hAABBCCDD);
    @(negedge clock);
    check("rst-store byte0 write", 32'(ram_write_ena), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1 check("rst-store gated write", 32'(ram_write_ena), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst-store resp_valid", 32'(resp_valid), 32'd0);
    check("rst-store req_ready", 32'(req_ready), 32'd1);
    check("rst-store mem40", 32'(mem[12'h040]), 32'hDD);
    check("rst-store mem41", 32'(mem[12'h041]), 32'h00);
    check("rst-store mem42", 32'(mem[12'h042]), 32'h00);

    // resp_ready while no response is pending.
    @(negedge clock);
    resp_ready = 1'b1;
    @(negedge clock);
    check("stray resp_ready req_ready", 32'(req_ready), 32'd1);
    check("stray resp_ready resp_valid", 32'(resp_valid), 32'd0);
    resp_ready = 1'b0;

    // The response must stay stable while resp_ready is held low.
    send_req(1'b0, 3'b010, 32'h10, 32'h0);
    wait_resp(lat, wr);
    check("hold latency", 32'(lat), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold resp_valid", 32'(resp_valid), 32'd1);
      check("hold resp_rdata", resp_rdata, 32'h12340080);
      check("hold req_ready", 32'(req_ready), 32'd0);
    end
    ack();
    @(negedge clock);
    check("after ack resp_valid", 32'(resp_valid), 32'd0);
    check("after ack req_ready", 32'(req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
